// File: rtl/vector_accumulate_unit_pkg.sv
`default_nettype none
// ============================================================================
// vector_accumulate_unit_pkg: op encodings and firmware byte decode
// Rev 1.0
// ============================================================================
package vector_accumulate_unit_pkg;

  typedef enum logic [1:0] {
    OP_PASS = 2'd0,
    OP_SUM  = 2'd1,
    OP_MAX  = 2'd2
  } op_e;

  // Unrecognised firmware bytes fall back to pass-through.
  function automatic op_e decode_op(input logic [7:0] raw);
    case (raw)
      8'd1:    decode_op = OP_SUM;
      8'd2:    decode_op = OP_MAX;
      default: decode_op = OP_PASS;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/vector_combine_lane.sv
`default_nettype none
// ============================================================================
// vector_combine_lane: next accumulator value for one lane (load / sum / max)
// Rev 1.0
// ============================================================================
module vector_combine_lane
  import vector_accumulate_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  load,
  input  logic [1:0]            op,
  input  logic [DATA_WIDTH-1:0] acc,
  input  logic [DATA_WIDTH-1:0] data,
  output logic [DATA_WIDTH-1:0] result
);

  always_comb begin
    result = acc + data;
    if (load) begin
      result = data;
    end else if (op == OP_MAX) begin
      result = (data > acc) ? data : acc;
    end
  end

endmodule
`default_nettype wire

// File: rtl/vector_accumulate_unit.sv
`default_nettype none
// ============================================================================
// vector_accumulate_unit: per-chain pass-through / frame sum / frame max
// Rev 1.0
// ============================================================================
module vector_accumulate_unit
  import vector_accumulate_unit_pkg::*;
#(
  parameter int N                  = 8,
  parameter int DATA_WIDTH         = 32,
  parameter int MAX_CHAINS         = 4,
  parameter int PERSONAL_CONFIG_ID = 1,
  parameter logic [MAX_CHAINS*8-1:0] INITIAL_FIRMWARE_OP = '0,
  localparam int CHAIN_W = (MAX_CHAINS > 1) ? $clog2(MAX_CHAINS) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    tracing,
  input  logic                    valid_in,
  input  logic [1:0]              eof_in,
  input  logic [1:0]              bof_in,
  input  logic [CHAIN_W-1:0]      chainId_in,
  input  logic [7:0]              configId,
  input  logic [7:0]              configData,
  input  logic [N*DATA_WIDTH-1:0] vector_in,
  output logic [N*DATA_WIDTH-1:0] vector_out,
  output logic [CHAIN_W-1:0]      chainId_out,
  output logic                    valid_out,
  output logic [1:0]              eof_out,
  output logic [1:0]              bof_out
);

  localparam int               CNT_W      = $clog2(MAX_CHAINS + 1);
  localparam logic [CNT_W-1:0] C_CNT_FULL = CNT_W'(MAX_CHAINS);
  localparam logic [7:0]       C_MY_ID    = 8'(PERSONAL_CONFIG_ID);

  logic [7:0]            r_fw_op     [MAX_CHAINS];
  op_e                   r_active_op [MAX_CHAINS];
  logic [CNT_W-1:0]      r_byte_cnt;
  logic [DATA_WIDTH-1:0] r_acc       [MAX_CHAINS][N];

  op_e                   w_op;
  logic                  w_accumulate;
  logic                  w_cfg_hit;
  logic [N*DATA_WIDTH-1:0] w_acc_vec;

  // A freshly written op only takes effect when its chain sees a bof.
  assign w_op         = bof_in[0] ? decode_op(r_fw_op[chainId_in]) : r_active_op[chainId_in];
  assign w_accumulate = tracing && valid_in && (w_op != OP_PASS);
  assign w_cfg_hit    = !tracing && (configId == C_MY_ID);

  for (genvar l = 0; l < N; l++) begin : g_lane
    vector_combine_lane #(
      .DATA_WIDTH(DATA_WIDTH)
    ) u_lane (
      .load   (bof_in[0]),
      .op     (w_op),
      .acc    (r_acc[chainId_in][l]),
      .data   (vector_in[l*DATA_WIDTH +: DATA_WIDTH]),
      .result (w_acc_vec[l*DATA_WIDTH +: DATA_WIDTH])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_byte_cnt <= '0;
      for (int c = 0; c < MAX_CHAINS; c++) begin
        r_fw_op[c]     <= INITIAL_FIRMWARE_OP[c*8 +: 8];
        r_active_op[c] <= decode_op(INITIAL_FIRMWARE_OP[c*8 +: 8]);
      end
    end else begin
      if (w_cfg_hit) begin
        // Counter saturates at MAX_CHAINS so surplus bytes are dropped.
        if (r_byte_cnt != C_CNT_FULL) begin
          r_fw_op[r_byte_cnt[CHAIN_W-1:0]] <= configData;
          r_byte_cnt <= r_byte_cnt + CNT_W'(1);
        end
      end else begin
        r_byte_cnt <= '0;
      end
      if (tracing && valid_in && bof_in[0]) begin
        r_active_op[chainId_in] <= w_op;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < MAX_CHAINS; c++) begin
        for (int l = 0; l < N; l++) begin
          r_acc[c][l] <= '0;
        end
      end
    end else if (w_accumulate) begin
      for (int l = 0; l < N; l++) begin
        r_acc[chainId_in][l] <= w_acc_vec[l*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_out   <= 1'b0;
      vector_out  <= '0;
      chainId_out <= '0;
      eof_out     <= 2'b00;
      bof_out     <= 2'b00;
    end else begin
      valid_out <= 1'b0;
      if (tracing && valid_in) begin
        if (w_op == OP_PASS) begin
          valid_out   <= 1'b1;
          vector_out  <= vector_in;
          chainId_out <= chainId_in;
          eof_out     <= eof_in;
          bof_out     <= bof_in;
        end else if (eof_in[0]) begin
          valid_out   <= 1'b1;
          vector_out  <= w_acc_vec;
          chainId_out <= chainId_in;
          eof_out     <= eof_in;
          bof_out     <= 2'b01;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vector_accumulate_unit.sv
`default_nettype none
// ============================================================================
// tb_vector_accumulate_unit: directed scoreboard bench for vector_accumulate_unit
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_vector_accumulate_unit;

  localparam int N  = 8;
  localparam int DW = 32;
  localparam int VW = N * DW;

  typedef struct {
    logic          valid;
    logic [VW-1:0] vec;
    logic [1:0]    ch;
    logic [1:0]    eof;
    logic [1:0]    bof;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          tracing = 1'b0;
  logic          valid_in = 1'b0;
  logic [1:0]    eof_in = 2'b00;
  logic [1:0]    bof_in = 2'b00;
  logic [1:0]    chainId_in = 2'd0;
  logic [7:0]    configId = 8'd0;
  logic [7:0]    configData = 8'd0;
  logic [VW-1:0] vector_in = '0;
  logic [VW-1:0] vector_out;
  logic [1:0]    chainId_out;
  logic          valid_out;
  logic [1:0]    eof_out;
  logic [1:0]    bof_out;

  int            checks = 0;
  int            errors = 0;
  exp_t          sb[$];
  logic [VW-1:0] mx;

  always #5 clk = ~clk;

  vector_accumulate_unit #(
    .N                   (N),
    .DATA_WIDTH          (DW),
    .MAX_CHAINS          (4),
    .PERSONAL_CONFIG_ID  (1),
    .INITIAL_FIRMWARE_OP (32'h0000_0100)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .tracing     (tracing),
    .valid_in    (valid_in),
    .eof_in      (eof_in),
    .bof_in      (bof_in),
    .chainId_in  (chainId_in),
    .configId    (configId),
    .configData  (configData),
    .vector_in   (vector_in),
    .vector_out  (vector_out),
    .chainId_out (chainId_out),
    .valid_out   (valid_out),
    .eof_out     (eof_out),
    .bof_out     (bof_out)
  );

  function automatic logic [VW-1:0] fill(input int base, input int inc);
    for (int l = 0; l < N; l++) fill[l*DW +: DW] = DW'(base + inc * l);
  endfunction

  task automatic check_pop(input string tag);
    exp_t e;
    checks++;
    assert (sb.size() > 0) else begin
      errors++;
      $error("FAIL %s scoreboard: got empty queue, valid_out=%0b, exp one entry", tag, valid_out);
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      assert (valid_out === e.valid) else begin
        errors++;
        $error("FAIL %s valid_out: got %0b exp %0b", tag, valid_out, e.valid);
      end
      if (e.valid) begin
        checks++;
        assert ({chainId_out, eof_out, bof_out, vector_out} === {e.ch, e.eof, e.bof, e.vec}) else begin
          errors++;
          $error("FAIL %s output: got ch=%0d eof=%b bof=%b vec=%h exp ch=%0d eof=%b bof=%b vec=%h",
                 tag, chainId_out, eof_out, bof_out, vector_out, e.ch, e.eof, e.bof, e.vec);
        end
      end
    end
  endtask

  task automatic step(input string tag, input logic tr, input logic v, input logic [1:0] ch,
                      input logic [1:0] b, input logic [1:0] e, input logic [VW-1:0] vec,
                      input logic exp_v, input logic [VW-1:0] exp_vec, input logic [1:0] exp_b);
    tracing    = tr;
    valid_in   = v;
    chainId_in = ch;
    bof_in     = b;
    eof_in     = e;
    vector_in  = vec;
    sb.push_back('{valid: exp_v, vec: exp_vec, ch: ch, eof: e, bof: exp_b});
    @(posedge clk);
    #1;
    check_pop(tag);
  endtask

  // Config byte presented with valid_in high to show tracing=0 suppresses output.
  task automatic cfg(input string tag, input logic [7:0] id, input logic [7:0] data);
    configId   = id;
    configData = data;
    step(tag, 1'b0, 1'b1, 2'd0, 2'b01, 2'b01, fill(99, 1), 1'b0, '0, 2'b00);
  endtask

  task automatic check_reset_state(input string tag);
    checks++;
    assert ({valid_out, eof_out, bof_out, chainId_out} === 7'b0 && vector_out === '0) else begin
      errors++;
      $error("FAIL %s reset outputs: got v=%0b eof=%b bof=%b ch=%0d vec=%h exp all zero",
             tag, valid_out, eof_out, bof_out, chainId_out, vector_out);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("reset");
    reset = 1'b0;

    // Pass-through on chain 0 (initial op 0)
    step("idle0", 1, 0, 0, 2'b00, 2'b00, fill(7, 0), 0, '0, 2'b00);
    step("pass_1to8", 1, 1, 0, 2'b01, 2'b01, fill(1, 1), 1, fill(1, 1), 2'b01);
    step("pass_flags", 1, 1, 0, 2'b10, 2'b10, fill(40, 3), 1, fill(40, 3), 2'b10);
    step("pass_idle", 1, 0, 0, 2'b01, 2'b01, fill(5, 5), 0, '0, 2'b00);

    // Chain ops {0,1,2,1}, then a foreign id clears the byte counter
    cfg("cfg_a0", 8'd1, 8'd0);
    cfg("cfg_a1", 8'd1, 8'd1);
    cfg("cfg_a2", 8'd1, 8'd2);
    cfg("cfg_a3", 8'd1, 8'd1);
    cfg("cfg_other", 8'd2, 8'd9);

    // Chain 1 sum of three all-ones vectors
    step("sum_b", 1, 1, 1, 2'b01, 2'b00, fill(1, 0), 0, '0, 2'b00);
    step("sum_m", 1, 1, 1, 2'b00, 2'b00, fill(1, 0), 0, '0, 2'b00);
    step("sum_e", 1, 1, 1, 2'b00, 2'b01, fill(1, 0), 1, fill(3, 0), 2'b01);
    step("sum_idle", 1, 0, 1, 2'b00, 2'b01, fill(1, 0), 0, '0, 2'b00);

    // Chain 2 unsigned max
    for (int l = 0; l < N; l++) mx[l*DW +: DW] = (5 + l > 9) ? DW'(5 + l) : DW'(9);
    step("max_b", 1, 1, 2, 2'b01, 2'b00, fill(5, 1), 0, '0, 2'b00);
    step("max_m", 1, 1, 2, 2'b00, 2'b00, fill(9, 0), 0, '0, 2'b00);
    step("max_e", 1, 1, 2, 2'b00, 2'b01, fill(2, 0), 1, mx, 2'b01);

    // Chain 3 sum wrap, then single-vector frame
    step("wrap_b", 1, 1, 3, 2'b01, 2'b00, fill(-1, 0), 0, '0, 2'b00);
    step("wrap_e", 1, 1, 3, 2'b00, 2'b01, fill(2, 0), 1, fill(1, 0), 2'b01);
    step("single", 1, 1, 3, 2'b01, 2'b01, fill(3, 3), 1, fill(3, 3), 2'b01);

    // Chains 0 and 1 both sum, interleaved
    cfg("cfg_b0", 8'd1, 8'd1);
    cfg("cfg_b1", 8'd1, 8'd1);
    cfg("cfg_b_clr", 8'd0, 8'd0);
    step("il_b0", 1, 1, 0, 2'b01, 2'b00, fill(1, 0), 0, '0, 2'b00);
    step("il_b1", 1, 1, 1, 2'b01, 2'b00, fill(2, 0), 0, '0, 2'b00);
    step("il_e0", 1, 1, 0, 2'b00, 2'b01, fill(1, 0), 1, fill(2, 0), 2'b01);
    step("il_e1", 1, 1, 1, 2'b00, 2'b01, fill(2, 0), 1, fill(4, 0), 2'b01);

    // Bytes 2,1,0,1,7: fifth byte must not land on chain 0
    cfg("cfg_c0", 8'd1, 8'd2);
    cfg("cfg_c1", 8'd1, 8'd1);
    cfg("cfg_c2", 8'd1, 8'd0);
    cfg("cfg_c3", 8'd1, 8'd1);
    cfg("cfg_c4", 8'd1, 8'd7);
    cfg("cfg_c_clr", 8'd0, 8'd0);
    step("c_max_b", 1, 1, 0, 2'b01, 2'b00, fill(3, 0), 0, '0, 2'b00);
    step("c_max_e", 1, 1, 0, 2'b00, 2'b01, fill(7, 0), 1, fill(7, 0), 2'b01);
    step("c_pass2", 1, 1, 2, 2'b01, 2'b00, fill(10, 1), 1, fill(10, 1), 2'b01);

    // Reset in the middle of a chain 1 sum frame
    step("rst_b", 1, 1, 1, 2'b01, 2'b00, fill(5, 0), 0, '0, 2'b00);
    step("rst_m", 1, 1, 1, 2'b00, 2'b00, fill(5, 0), 0, '0, 2'b00);
    valid_in = 1'b0;
    #2 reset = 1'b1;
    #1;
    check_reset_state("async_reset");
    @(posedge clk);
    #1;
    reset = 1'b0;
    step("rst_eof", 1, 1, 1, 2'b00, 2'b01, fill(4, 0), 1, fill(4, 0), 2'b01);
    step("rst_idle", 1, 0, 1, 2'b00, 2'b00, fill(4, 0), 0, '0, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vector_accumulate_unit.md
VECTOR_ACCUMULATE_UNIT -- requirements
Module: vector_accumulate_unit

Interface
REQ-001 SHALL have parameter N, default 8: vector lanes.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: lane width, bits.
REQ-003 SHALL have parameter MAX_CHAINS, default 4: number of independent chains.
REQ-004 SHALL have parameter PERSONAL_CONFIG_ID, default 1: configId this unit answers to.
REQ-005 SHALL have parameter INITIAL_FIRMWARE_OP, default all 0: per-chain op loaded at reset.
REQ-006 SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-007 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-008 SHALL have port tracing, input, 1: 1 = process data, 0 = configure.
REQ-009 SHALL have port valid_in, input, 1: input vector valid.
REQ-010 SHALL have port eof_in, input, 2: bit0 = last vector of frame.
REQ-011 SHALL have port bof_in, input, 2: bit0 = first vector of frame.
REQ-012 SHALL have port chainId_in, input, clog2(MAX_CHAINS): chain of input vector.
REQ-013 SHALL have port configId, input, 8: selected config target.
REQ-014 SHALL have port configData, input, 8: config byte.
REQ-015 SHALL have port vector_in, input, N x DATA_WIDTH: upstream filter-reduce result.
REQ-016 SHALL have ports vector_out, chainId_out, valid_out, eof_out, bof_out, outputs, same widths as the matching inputs: registered result.

Function
REQ-017 SHALL decode firmware_op[chain]: 0 = pass-through, 1 = element-wise sum over frame, 2 = element-wise unsigned max over frame; values 3-255 SHALL behave as 0.
REQ-018 SHALL, for op 0 and tracing=1, register inputs to outputs with latency exactly 1 cycle.
REQ-019 SHALL hold one N x DATA_WIDTH accumulator per chain.
REQ-020 SHALL, for op 1/2 and valid_in=1 with bof_in[0]=1, load the accumulator with vector_in (previous contents discarded).
REQ-021 SHALL, for op 1/2 and valid_in=1 with bof_in[0]=0, combine vector_in into the accumulator (sum wraps modulo 2^DATA_WIDTH; max unsigned).
REQ-022 SHALL, for op 1/2, assert valid_out one cycle after an input with eof_in[0]=1, with vector_out = accumulator including that input, eof_out = eof_in, bof_out = 2'b01, chainId_out = chainId_in.
REQ-023 SHALL, for op 1/2, keep valid_out=0 for non-eof inputs.
REQ-024 SHALL treat bof_in[0]=eof_in[0]=1 on one vector as a single-vector frame: output equals vector_in.
REQ-025 SHALL ignore inputs with valid_in=0 (no accumulator change, valid_out=0 next cycle).
REQ-026 SHALL keep frames of different chains independent when interleaved cycle by cycle.
REQ-027 SHALL, with tracing=0, drive valid_out=0 and leave accumulators unchanged.
REQ-028 SHALL, with tracing=0 and configId==PERSONAL_CONFIG_ID, write configData to firmware_op[byte_counter] for byte_counter < MAX_CHAINS, then increment byte_counter, ignoring further bytes.
REQ-029 SHALL clear byte_counter whenever configId != PERSONAL_CONFIG_ID or tracing=1.
REQ-030 SHALL apply a new op starting at the next bof of that chain; firmware writes do not clear accumulators.

Reset
REQ-031 SHALL, on reset, immediately drive valid_out=0, eof_out=0, bof_out=0, chainId_out=0, vector_out all zero.
REQ-032 SHALL, on reset, clear all accumulators and byte_counter and reload firmware_op from INITIAL_FIRMWARE_OP.
REQ-033 SHALL, on reset mid-frame, discard the partial frame; accumulation resumes only at the next bof.

Structure
REQ-034 SHALL place op encodings (PASS=0, SUM=1, MAX=2) in the shared debugger package.
REQ-035 SHALL instantiate one sub-module, vector_combine_lane, per lane (sum/max/load of one element); no RAM macro required.

Verification
REQ-036 SHALL cover: chain 0 op 0, valid vector [1..8] -> same vector, valid_out=1 exactly 1 cycle later.
REQ-037 SHALL cover: chain 1 op 1, frame of 3 vectors all-ones (bof first, eof last) -> one output all 3s, valid_out pulses once.
REQ-038 SHALL cover: chain 2 op 2, lane0 values 5,9,2 -> output lane0=9; op 1 with 0xFFFFFFFF+2 -> lane=1 (wrap).
REQ-039 SHALL cover: interleaved chains 0 and 1 (op 1) alternating each cycle, 2 vectors each of 1s and 2s -> outputs 2s on chain 0 and 4s on chain 1.
REQ-040 SHALL cover: tracing=0, configId=1, bytes 2,1,0,1,7 -> firmware_op = {2,1,0,1}, fifth byte ignored, valid_out=0 throughout.
REQ-041 SHALL cover: reset asserted after 2 vectors of a sum frame -> outputs zero asynchronously; later eof without bof yields no stale contribution (accumulator zero).
